// File: rtl/csram_dual_port_banked_if.sv
// Requester-side bus for one CSRAM port.
//   master : requester (drives CS/ADDR/WREN/WDATA, sees READY/RVALID/RDATA)
//   slave  : memory subsystem
// Signals:
//   CS      request this cycle
//   ADDR    word address
//   WREN    byte write enables, all-zero = read
//   WDATA   write data
//   READY   request accepted this cycle (1 when CS=0)
//   RVALID  read data valid, one-cycle pulse per returned read
//   RDATA   read data, held until the port's next read returns
interface csram_dual_port_banked_if #(
    parameter int AW = 13,
    parameter int DW = 32
);
    localparam int NB = DW / 8;

    logic          CS;
    logic [AW-1:0] ADDR;
    logic [NB-1:0] WREN;
    logic [DW-1:0] WDATA;
    logic          READY;
    logic          RVALID;
    logic [DW-1:0] RDATA;

    modport master (output CS, ADDR, WREN, WDATA, input READY, RVALID, RDATA);
    modport slave  (input CS, ADDR, WREN, WDATA, output READY, RVALID, RDATA);
endinterface

// File: rtl/csram_dual_port_banked.sv
// Banked CSRAM shared by two requesters (p0 = CPU, p1 = DMA).
// NUM_BANKS single-ported banks; different-bank accesses proceed in parallel,
// same-bank collisions are resolved round-robin and the loser sees READY=0.
// Ports:
//   SRAMHCLK    clock
//   SRAMHRESET  synchronous active-high reset
//   p0, p1      requester buses (slave side)
//   STALLCLR    clear the conflict counter
//   STALLCNT    saturating count of conflict cycles
module csram_dual_port_banked #(
    parameter int AW        = 13,
    parameter int DW        = 32,
    parameter int NUM_BANKS = 2,
    parameter int BANK_MODE = 0
) (
    input  logic                      SRAMHCLK,
    input  logic                      SRAMHRESET,
    csram_dual_port_banked_if.slave   p0,
    csram_dual_port_banked_if.slave   p1,
    input  logic                      STALLCLR,
    output logic [15:0]               STALLCNT
);
    localparam int NB    = DW / 8;
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int RW    = AW - BW;
    localparam int DEPTH = 2 ** RW;

    logic [1:0]                cs;
    logic [1:0][AW-1:0]        addr;
    logic [1:0][NB-1:0]        wren;
    logic [1:0][DW-1:0]        wdata;
    logic [1:0][BW-1:0]        bank;
    logic [1:0][RW-1:0]        row;
    logic [1:0]                grant;
    logic                      conflict;
    logic                      ptr;        // 0: p0 wins next conflict, 1: p1

    logic [1:0]                rvalid;
    logic [1:0][BW-1:0]        rd_bank_q;  // bank that serves the returning read
    logic [1:0][DW-1:0]        hold;
    logic [DW-1:0]             bank_rd [NUM_BANKS];

    assign cs    = {p1.CS, p0.CS};
    assign addr  = {p1.ADDR, p0.ADDR};
    assign wren  = {p1.WREN, p0.WREN};
    assign wdata = {p1.WDATA, p0.WDATA};

    for (genvar p = 0; p < 2; p++) begin : g_split
        if (BANK_MODE == 0) begin : g_hi
            assign bank[p] = addr[p][AW-1 -: BW];
            assign row[p]  = addr[p][RW-1:0];
        end else begin : g_lo
            assign bank[p] = addr[p][BW-1:0];
            assign row[p]  = addr[p][AW-1:BW];
        end
    end

    assign conflict = cs[0] & cs[1] & (bank[0] == bank[1]);
    assign grant[0] = cs[0] & (~conflict | ~ptr);
    assign grant[1] = cs[1] & (~conflict |  ptr);

    assign p0.READY = ~cs[0] | grant[0];
    assign p1.READY = ~cs[1] | grant[1];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] q;
        logic          sel0, sel1, en;
        logic [RW-1:0] brow;
        logic [NB-1:0] bwe;
        logic [DW-1:0] bwd;

        // At most one port is granted per bank, so a simple mux suffices.
        assign sel0 = grant[0] & (bank[0] == BW'(b));
        assign sel1 = grant[1] & (bank[1] == BW'(b));
        assign en   = sel0 | sel1;
        assign brow = sel1 ? row[1]   : row[0];
        assign bwe  = sel1 ? wren[1]  : wren[0];
        assign bwd  = sel1 ? wdata[1] : wdata[0];

        // q only moves on reads so a returning read is never disturbed by a write.
        always_ff @(posedge SRAMHCLK) begin
            if (en) begin
                for (int i = 0; i < NB; i++)
                    if (bwe[i]) mem[brow][8*i +: 8] <= bwd[8*i +: 8];
                if (bwe == '0) q <= mem[brow];
            end
        end
        assign bank_rd[b] = q;
    end

    always_ff @(posedge SRAMHCLK) begin
        if (SRAMHRESET) begin
            rvalid    <= '0;
            rd_bank_q <= '0;
            hold      <= '0;
            ptr       <= 1'b0;
            STALLCNT  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rvalid[p] <= grant[p] & (wren[p] == '0);
                if (grant[p] && wren[p] == '0) rd_bank_q[p] <= bank[p];
                // Capture bank output at the end of the valid cycle; the bank may
                // be reused by the other port afterwards.
                if (rvalid[p]) hold[p] <= bank_rd[rd_bank_q[p]];
            end
            if (conflict) ptr <= ~ptr;   // loser gets priority next time
            if (STALLCLR)
                STALLCNT <= '0;
            else if (conflict && STALLCNT != 16'hFFFF)
                STALLCNT <= STALLCNT + 16'd1;
        end
    end

    assign p0.RVALID = rvalid[0];
    assign p1.RVALID = rvalid[1];
    assign p0.RDATA  = rvalid[0] ? bank_rd[rd_bank_q[0]] : hold[0];
    assign p1.RDATA  = rvalid[1] ? bank_rd[rd_bank_q[1]] : hold[1];
endmodule

// File: tb/tb_csram_dual_port_banked.sv
module tb_csram_dual_port_banked;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr0, clr1;
    logic [15:0] cnt0, cnt1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    csram_dual_port_banked_if #(.AW(13), .DW(32)) a0 ();
    csram_dual_port_banked_if #(.AW(13), .DW(32)) a1 ();
    csram_dual_port_banked_if #(.AW(13), .DW(32)) b0 ();
    csram_dual_port_banked_if #(.AW(13), .DW(32)) b1 ();

    csram_dual_port_banked #(.AW(13), .DW(32), .NUM_BANKS(2), .BANK_MODE(0)) u0 (
        .SRAMHCLK(clk), .SRAMHRESET(rst), .p0(a0), .p1(a1), .STALLCLR(clr0), .STALLCNT(cnt0));
    csram_dual_port_banked #(.AW(13), .DW(32), .NUM_BANKS(4), .BANK_MODE(1)) u1 (
        .SRAMHCLK(clk), .SRAMHRESET(rst), .p0(b0), .p1(b1), .STALLCLR(clr1), .STALLCNT(cnt1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drv(input int p, input logic cs, input logic [12:0] ad,
                       input logic [3:0] we, input logic [31:0] wd);
        case (p)
            0: begin a0.CS = cs; a0.ADDR = ad; a0.WREN = we; a0.WDATA = wd; end
            1: begin a1.CS = cs; a1.ADDR = ad; a1.WREN = we; a1.WDATA = wd; end
            2: begin b0.CS = cs; b0.ADDR = ad; b0.WREN = we; b0.WDATA = wd; end
            default: begin b1.CS = cs; b1.ADDR = ad; b1.WREN = we; b1.WDATA = wd; end
        endcase
    endtask

    task automatic idle();
        for (int p = 0; p < 4; p++) drv(p, 1'b0, '0, '0, '0);
    endtask

    // random-phase reference state
    logic [31:0] mdl [8];
    bit          rq_cs [2];
    int          rq_k [2];
    logic [3:0]  rq_we [2];
    logic [31:0] rq_wd [2];
    bit          stalled [2];
    bit          g [2];
    bit          ev [2];
    logic [31:0] er [2];
    int          pri;
    int          ecnt;
    bit          cf;

    function automatic logic [12:0] addr_of(input int k);
        return ((k >= 4) ? 13'h1000 : 13'h0000) + 13'h40 + 13'(k % 4);
    endfunction

    initial begin
        rst = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0;
        chk("rst_rvalid0", a0.RVALID, 0);
        chk("rst_rdata0", a0.RDATA, 0);
        chk("rst_rvalid1", a1.RVALID, 0);
        chk("rst_rdata1", a1.RDATA, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);

        // basic write then read
        drv(0, 1, 13'h0001, 4'hF, 32'hDEADBEEF); #1;
        chk("t1_wr_ready", a0.READY, 1);
        tick();
        chk("t1_wr_norvalid", a0.RVALID, 0);
        drv(0, 1, 13'h0001, 4'h0, 0);
        tick();
        chk("t1_rvalid", a0.RVALID, 1);
        chk("t1_rdata", a0.RDATA, 32'hDEADBEEF);
        drv(0, 0, 0, 0, 0);
        tick();
        chk("t1_rvalid_drop", a0.RVALID, 0);
        chk("t1_rdata_hold", a0.RDATA, 32'hDEADBEEF);

        // parallel accesses to different banks
        drv(0, 1, 13'h0002, 4'hF, 32'h22222222);
        tick();
        drv(0, 1, 13'h0002, 4'h0, 0);
        drv(1, 1, 13'h1002, 4'hF, 32'h55667788); #1;
        chk("t2_ready0", a0.READY, 1);
        chk("t2_ready1", a1.READY, 1);
        tick();
        chk("t2_rdata0", a0.RDATA, 32'h22222222);
        chk("t2_rvalid1", a1.RVALID, 0);
        chk("t2_cnt", cnt0, 0);
        drv(0, 0, 0, 0, 0);
        drv(1, 1, 13'h1002, 4'h0, 0);
        tick();
        chk("t2_rdata1", a1.RDATA, 32'h55667788);
        drv(1, 0, 0, 0, 0);

        // same-bank contention, alternating grants
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 13'h0010 + 13'(i), 4'hF, 32'hC0DE0000 + i);
            tick();
        end
        drv(0, 1, 13'h0010, 0, 0); drv(1, 1, 13'h0012, 0, 0); #1;
        chk("t3_c1_ready0", a0.READY, 1);
        chk("t3_c1_ready1", a1.READY, 0);
        tick();
        chk("t3_c1_rdata0", a0.RDATA, 32'hC0DE0000);
        chk("t3_c1_rvalid1", a1.RVALID, 0);
        chk("t3_c1_hold1", a1.RDATA, 32'h55667788);
        drv(0, 1, 13'h0011, 0, 0); #1;
        chk("t3_c2_ready0", a0.READY, 0);
        chk("t3_c2_ready1", a1.READY, 1);
        tick();
        chk("t3_c2_rvalid0", a0.RVALID, 0);
        chk("t3_c2_hold0", a0.RDATA, 32'hC0DE0000);
        chk("t3_c2_rdata1", a1.RDATA, 32'hC0DE0002);
        drv(1, 1, 13'h0013, 0, 0); #1;
        chk("t3_c3_ready0", a0.READY, 1);
        chk("t3_c3_ready1", a1.READY, 0);
        tick();
        chk("t3_c3_rdata0", a0.RDATA, 32'hC0DE0001);
        chk("t3_c3_hold1", a1.RDATA, 32'hC0DE0002);
        drv(0, 1, 13'h0010, 0, 0); #1;
        chk("t3_c4_ready0", a0.READY, 0);
        chk("t3_c4_ready1", a1.READY, 1);
        tick();
        chk("t3_c4_rdata1", a1.RDATA, 32'hC0DE0003);
        chk("t3_cnt", cnt0, 4);
        drv(1, 0, 0, 0, 0); #1;
        chk("t3_c5_ready0", a0.READY, 1);
        tick();
        chk("t3_c5_rdata0", a0.RDATA, 32'hC0DE0000);
        chk("t3_cnt_stays", cnt0, 4);

        // partial write, read back through the other port the next cycle
        drv(0, 1, 13'h0020, 4'hF, 32'hAAAAAAAA); tick();
        drv(0, 1, 13'h0020, 4'b0101, 32'h11223344); tick();
        drv(0, 0, 0, 0, 0); drv(1, 1, 13'h0020, 0, 0); tick();
        chk("t4_rvalid1", a1.RVALID, 1);
        chk("t4_partial", a1.RDATA, 32'hAA22AA44);
        drv(1, 0, 0, 0, 0);

        // low-bit banking, 4 banks
        drv(2, 1, 13'h0005, 4'hF, 32'h05050505);
        drv(3, 1, 13'h0009, 4'hF, 32'h09090909); #1;
        chk("t5_ready0", b0.READY, 1);
        chk("t5_ready1", b1.READY, 0);
        tick();
        chk("t5_cnt1", cnt1, 1);
        drv(2, 1, 13'h000D, 4'hF, 32'h0D0D0D0D); clr1 = 1'b1; #1;
        chk("t5_c2_ready0", b0.READY, 0);
        chk("t5_c2_ready1", b1.READY, 1);
        tick();
        chk("t5_clr_wins", cnt1, 0);
        clr1 = 1'b0; drv(3, 0, 0, 0, 0); #1;
        chk("t5_c3_ready0", b0.READY, 1);
        tick();
        chk("t5_cnt_zero", cnt1, 0);
        drv(2, 1, 13'h0004, 0, 0); drv(3, 1, 13'h0005, 0, 0); #1;
        chk("t5_nc_ready0", b0.READY, 1);
        chk("t5_nc_ready1", b1.READY, 1);
        tick();
        chk("t5_rd5", b1.RDATA, 32'h05050505);
        drv(2, 1, 13'h0009, 0, 0); drv(3, 1, 13'h000D, 0, 0);
        tick();  // conflict, p0 has priority again
        drv(2, 0, 0, 0, 0);
        tick();
        chk("t5_rd9", b0.RDATA, 32'h09090909);
        chk("t5_rdD", b1.RDATA, 32'h0D0D0D0D);
        idle();

        // reset after a grant; reset during a grant
        drv(0, 1, 13'h0001, 0, 0); drv(1, 1, 13'h0002, 0, 0); tick();  // ptr -> p1
        chk("t6_pre_rvalid", a0.RVALID, 1);
        idle(); rst = 1'b1; tick();
        chk("t6_rvalid", a0.RVALID, 0);
        chk("t6_rdata", a0.RDATA, 0);
        chk("t6_cnt", cnt0, 0);
        drv(0, 1, 13'h0001, 0, 0); tick();   // read under reset
        rst = 1'b0;
        chk("t6_rst_grant_rvalid", a0.RVALID, 0);
        drv(1, 1, 13'h0002, 0, 0); #1;
        chk("t6_ptr_p0_r0", a0.READY, 1);
        chk("t6_ptr_p0_r1", a1.READY, 0);
        drv(1, 0, 0, 0, 0); tick();
        chk("t6_retain", a0.RDATA, 32'hDEADBEEF);
        drv(0, 1, 13'h0020, 0, 0); tick();
        chk("t6_retain2", a0.RDATA, 32'hAA22AA44);
        idle();

        // randomized traffic against a reference model
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mdl[k] = $urandom;
            drv(0, 1, addr_of(k), 4'hF, mdl[k]);
            tick();
        end
        idle();
        tick();
        pri = 0; ecnt = 0; er[0] = 32'hDEADBEEF; er[1] = 0;
        er[0] = a0.RDATA;  // last init op was a write; hold is reset-cleared
        chk("rnd_init_hold", er[0], 0);
        er[0] = 0;
        stalled[0] = 0; stalled[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!stalled[p]) begin
                    rq_cs[p] = ($urandom_range(0, 3) != 0);
                    rq_k[p]  = $urandom_range(0, 7);
                    rq_we[p] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                    rq_wd[p] = $urandom;
                end
                drv(p, rq_cs[p], addr_of(rq_k[p]), rq_we[p], rq_wd[p]);
            end
            clr0 = ($urandom_range(0, 15) == 0);
            #1;
            cf = rq_cs[0] && rq_cs[1] && ((rq_k[0] / 4) == (rq_k[1] / 4));
            for (int p = 0; p < 2; p++) g[p] = rq_cs[p] && (!cf || pri == p);
            chk("rnd_ready0", a0.READY, !rq_cs[0] || g[0]);
            chk("rnd_ready1", a1.READY, !rq_cs[1] || g[1]);
            for (int p = 0; p < 2; p++) begin
                ev[p] = g[p] && rq_we[p] == 0;
                if (ev[p]) er[p] = mdl[rq_k[p]];
            end
            for (int p = 0; p < 2; p++)
                if (g[p] && rq_we[p] != 0)
                    for (int i = 0; i < 4; i++)
                        if (rq_we[p][i]) mdl[rq_k[p]][8*i +: 8] = rq_wd[p][8*i +: 8];
            if (cf) pri = 1 - pri;
            if (clr0) ecnt = 0;
            else if (cf && ecnt < 65535) ecnt++;
            for (int p = 0; p < 2; p++) stalled[p] = rq_cs[p] && !g[p];
            tick();
            chk("rnd_rvalid0", a0.RVALID, ev[0]);
            chk("rnd_rvalid1", a1.RVALID, ev[1]);
            chk("rnd_rdata0", a0.RDATA, er[0]);
            chk("rnd_rdata1", a1.RDATA, er[1]);
            chk("rnd_cnt", cnt0, ecnt);
        end
        idle(); clr0 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
